// File: rtl/ps2_key_event_fifo.sv
// PS/2 scan-code set 2 decoder feeding a show-ahead key event FIFO.
// Optional auto-repeat suppression is enabled by defining PS2_TYPEMATIC_FILTER_EN.
module ps2_key_event_fifo #(
  parameter int AW = 3
) (
  input  logic          inclock,
  input  logic          resetn,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic [7:0]    ev_code,
  output logic          ev_break,
  output logic          ev_ext,
  output logic          ev_valid,
  input  logic          ev_ready,
  output logic [AW:0]   ev_count,
  output logic          overflow,
  input  logic          ovf_clr,
  output logic [7:0]    last_data_received
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ZERO   = {(AW + 1){1'b0}};
  localparam logic [AW-1:0] PTR_ONE    = {{(AW - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_E0   = 2'd1,
    ST_F0   = 2'd2,
    ST_E0F0 = 2'd3
  } dec_state_t;

  function automatic logic is_control(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: is_control = 1'b1;
      default:                                                 is_control = 1'b0;
    endcase
  endfunction

  dec_state_t      state_r;
  dec_state_t      state_nx_s;
  logic            emit_s;
  logic            emit_brk_s;
  logic            emit_ext_s;
  logic            push_s;
  logic            pop_s;
  logic            full_s;
  logic            push_ok_s;
  logic            ovf_set_s;
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW:0]     count_r;
  logic            overflow_r;
  logic [7:0]      last_r;
  logic [9:0]      mem_r [DEPTH];
  logic [9:0]      head_s;

  // Decoder next state and event emission for the current byte.
  always_comb begin
    state_nx_s = state_r;
    emit_s     = 1'b0;
    emit_brk_s = 1'b0;
    emit_ext_s = 1'b0;
    if (rx_valid) begin
      if (is_control(rx_data)) begin
        state_nx_s = ST_IDLE;
      end else if (rx_data == 8'hF0) begin
        case (state_r)
          ST_IDLE: state_nx_s = ST_F0;
          ST_E0:   state_nx_s = ST_E0F0;
          ST_F0:   state_nx_s = ST_F0;
          ST_E0F0: state_nx_s = ST_E0F0;
          default: state_nx_s = ST_IDLE;
        endcase
      end else if ((rx_data == 8'hE0) && (state_r != ST_F0)) begin
        // After a lone F0 an E0 byte is not a legal prefix, so it falls through as a code.
        case (state_r)
          ST_IDLE: state_nx_s = ST_E0;
          ST_E0:   state_nx_s = ST_E0;
          ST_E0F0: state_nx_s = ST_E0F0;
          default: state_nx_s = ST_IDLE;
        endcase
      end else begin
        emit_s     = 1'b1;
        emit_brk_s = (state_r == ST_F0) || (state_r == ST_E0F0);
        emit_ext_s = (state_r == ST_E0) || (state_r == ST_E0F0);
        state_nx_s = ST_IDLE;
      end
    end else begin
      state_nx_s = state_r;
    end
  end

  // Decoder state register.
  always_ff @(posedge inclock) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Raw byte capture, including prefix and control bytes.
  always_ff @(posedge inclock) begin
    if (!resetn) begin
      last_r <= 8'hF0;
    end else if (rx_valid) begin
      last_r <= rx_data;
    end else begin
      last_r <= last_r;
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       held_valid_r;
  logic [8:0] held_key_r;
  logic       held_match_s;

  assign held_match_s = held_valid_r && (held_key_r == {emit_ext_s, rx_data});

  // Suppress repeated makes of the held key.
  always_comb begin
    if (emit_s && !emit_brk_s && held_match_s) begin
      push_s = 1'b0;
    end else begin
      push_s = emit_s;
    end
  end

  // Track the most recent make; its own break releases it.
  always_ff @(posedge inclock) begin
    if (!resetn) begin
      held_valid_r <= 1'b0;
      held_key_r   <= 9'h000;
    end else if (emit_s && !emit_brk_s && !held_match_s) begin
      held_valid_r <= 1'b1;
      held_key_r   <= {emit_ext_s, rx_data};
    end else if (emit_s && emit_brk_s && held_match_s) begin
      held_valid_r <= 1'b0;
      held_key_r   <= held_key_r;
    end else begin
      held_valid_r <= held_valid_r;
      held_key_r   <= held_key_r;
    end
  end
`else
  assign push_s = emit_s;
`endif

  assign full_s    = (count_r == FULL_COUNT);
  assign pop_s     = (count_r != CNT_ZERO) && ev_ready;
  assign push_ok_s = push_s && (!full_s || pop_s);
  assign ovf_set_s = push_s && full_s && !pop_s;

  // Event storage; entries are {ext, break, code}.
  always_ff @(posedge inclock) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= {emit_ext_s, emit_brk_s, rx_data};
    end
  end

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge inclock) begin
    if (!resetn) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= CNT_ZERO;
      overflow_r <= 1'b0;
    end else begin
      wr_ptr_r   <= push_ok_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_r   <= pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      count_r    <= count_r + {{AW{1'b0}}, push_ok_s} - {{AW{1'b0}}, pop_s};
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (ovf_clr) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  // Show-ahead head, forced to zero while empty.
  always_comb begin
    if (count_r != CNT_ZERO) begin
      head_s = mem_r[rd_ptr_r];
    end else begin
      head_s = 10'h000;
    end
  end

  assign ev_valid           = (count_r != CNT_ZERO);
  assign ev_code            = head_s[7:0];
  assign ev_break           = head_s[8];
  assign ev_ext             = head_s[9];
  assign ev_count           = count_r;
  assign overflow           = overflow_r;
  assign last_data_received = last_r;

endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Self-checking bench for ps2_key_event_fifo: queue-based reference model plus literal expectations.
module tb_ps2_key_event_fifo;

  localparam int AW = 3;
  localparam int DEPTH = 8;

  logic         inclock = 1'b0;
  logic         resetn = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic [7:0]   ev_code;
  logic         ev_break;
  logic         ev_ext;
  logic         ev_valid;
  logic         ev_ready = 1'b0;
  logic [AW:0]  ev_count;
  logic         overflow;
  logic         ovf_clr = 1'b0;
  logic [7:0]   last_data_received;

  ps2_key_event_fifo #(.AW(AW)) dut (
    .inclock(inclock), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .ev_code(ev_code), .ev_break(ev_break), .ev_ext(ev_ext), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .ev_count(ev_count), .overflow(overflow), .ovf_clr(ovf_clr),
    .last_data_received(last_data_received)
  );

  always #5 inclock = ~inclock;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } ev_t;

  ev_t        mq[$];
  logic       m_ovf = 1'b0;
  logic [7:0] m_last = 8'hF0;
  logic       m_ext_pend = 1'b0;
  logic       m_brk_pend = 1'b0;
  logic       m_held_v = 1'b0;
  logic [8:0] m_held = 9'h000;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_ctrl(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFA) ||
           (b >= 8'hFC);
  endfunction

  task automatic model_edge();
    ev_t e;
    logic emit;
    logic pop;
    logic set;
    if (!resetn) begin
      mq.delete();
      m_ovf = 1'b0; m_last = 8'hF0;
      m_ext_pend = 1'b0; m_brk_pend = 1'b0;
      m_held_v = 1'b0; m_held = 9'h000;
      return;
    end
    pop = (mq.size() > 0) && ev_ready;
    emit = 1'b0;
    e = '0;
    if (rx_valid) begin
      m_last = rx_data;
      if (is_ctrl(rx_data)) begin
        m_ext_pend = 1'b0; m_brk_pend = 1'b0;
      end else if (rx_data == 8'hF0) begin
        m_brk_pend = 1'b1;
      end else if (rx_data == 8'hE0 && !(m_brk_pend && !m_ext_pend)) begin
        m_ext_pend = 1'b1;
      end else begin
        e.code = rx_data; e.brk = m_brk_pend; e.ext = m_ext_pend;
        emit = 1'b1;
        m_ext_pend = 1'b0; m_brk_pend = 1'b0;
      end
    end
`ifdef PS2_TYPEMATIC_FILTER_EN
    if (emit) begin
      if (!e.brk) begin
        if (m_held_v && m_held == {e.ext, e.code}) emit = 1'b0;
        else begin m_held_v = 1'b1; m_held = {e.ext, e.code}; end
      end else if (m_held_v && m_held == {e.ext, e.code}) begin
        m_held_v = 1'b0;
      end
    end
`endif
    set = 1'b0;
    if (pop) void'(mq.pop_front());
    if (emit) begin
      if (mq.size() == DEPTH) set = 1'b1;
      else mq.push_back(e);
    end
    if (set) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
  endtask

  // One clock: apply inputs, advance the model at the edge, compare at the falling edge.
  task automatic cycle(input logic rv, input logic [7:0] d, input logic rdy, input logic clr);
    rx_valid = rv; rx_data = d; ev_ready = rdy; ovf_clr = clr;
    @(posedge inclock);
    model_edge();
    #1;
    rx_valid = 1'b0; ev_ready = 1'b0; ovf_clr = 1'b0;
    @(negedge inclock);
    chk("m_valid", 32'(ev_valid), 32'(mq.size() != 0));
    chk("m_count", 32'(ev_count), 32'(mq.size()));
    chk("m_overflow", 32'(overflow), 32'(m_ovf));
    chk("m_last", 32'(last_data_received), 32'(m_last));
    if (mq.size() != 0) begin
      chk("m_code", 32'(ev_code), 32'(mq[0].code));
      chk("m_break", 32'(ev_break), 32'(mq[0].brk));
      chk("m_ext", 32'(ev_ext), 32'(mq[0].ext));
    end
  endtask

  task automatic send(input logic [7:0] d);
    cycle(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic pop_expect(input logic [7:0] c, input logic b, input logic x);
    chk("head_valid", 32'(ev_valid), 32'd1);
    chk("head_code", 32'(ev_code), 32'(c));
    chk("head_break", 32'(ev_break), 32'(b));
    chk("head_ext", 32'(ev_ext), 32'(x));
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    logic [7:0] seq_a [5];
    resetn = 1'b0;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'h1C, 1'b1, 1'b0);
    chk("rst_valid", 32'(ev_valid), 32'd0);
    chk("rst_count", 32'(ev_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_last", 32'(last_data_received), 32'hF0);
    chk("rst_code", 32'(ev_code), 32'd0);
    chk("rst_brk", 32'(ev_break), 32'd0);
    chk("rst_ext", 32'(ev_ext), 32'd0);
    resetn = 1'b1;

    send(8'h1C); send(8'hF0); send(8'h1C);
    chk("t1_last", 32'(last_data_received), 32'h1C);
    chk("t1_count", 32'(ev_count), 32'd2);
    pop_expect(8'h1C, 1'b0, 1'b0);
    pop_expect(8'h1C, 1'b1, 1'b0);

    seq_a = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
    foreach (seq_a[i]) send(seq_a[i]);
    chk("t2_count", 32'(ev_count), 32'd2);
    pop_expect(8'h75, 1'b0, 1'b1);
    pop_expect(8'h75, 1'b1, 1'b1);

    for (int i = 0; i < 9; i++) send(8'h15 + 8'(i));
    chk("t3_count", 32'(ev_count), 32'd8);
    chk("t3_ovf", 32'(overflow), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t3_clr", 32'(overflow), 32'd0);
    chk("t4_head", 32'(ev_code), 32'h15);
    cycle(1'b1, 8'h2A, 1'b1, 1'b0);
    chk("t4_count", 32'(ev_count), 32'd8);
    chk("t4_ovf", 32'(overflow), 32'd0);
    for (int i = 1; i < 8; i++) pop_expect(8'h15 + 8'(i), 1'b0, 1'b0);
    pop_expect(8'h2A, 1'b0, 1'b0);
    chk("t4_empty", 32'(ev_valid), 32'd0);

    for (int i = 0; i < 8; i++) send(8'h30 + 8'(i));
    cycle(1'b1, 8'h40, 1'b0, 1'b1);
    chk("t5_setwins", 32'(overflow), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) pop_expect(8'h30 + 8'(i), 1'b0, 1'b0);

    send(8'hE0); send(8'hFA); send(8'h1C);
    chk("t6_count", 32'(ev_count), 32'd1);
    chk("t6_last", 32'(last_data_received), 32'h1C);
    pop_expect(8'h1C, 1'b0, 1'b0);

    send(8'h22);
    send(8'hF0);
    resetn = 1'b0;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t7_flushed", 32'(ev_count), 32'd0);
    resetn = 1'b1;
    send(8'h1C);
    pop_expect(8'h1C, 1'b0, 1'b0);

    send(8'hF0); send(8'hE0);
    pop_expect(8'hE0, 1'b1, 1'b0);

    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
`ifdef PS2_TYPEMATIC_FILTER_EN
    chk("t8_count", 32'(ev_count), 32'd3);
    pop_expect(8'h1C, 1'b0, 1'b0);
    pop_expect(8'h1C, 1'b1, 1'b0);
    pop_expect(8'h1C, 1'b0, 1'b0);
`else
    chk("t8_count", 32'(ev_count), 32'd5);
    pop_expect(8'h1C, 1'b0, 1'b0);
    pop_expect(8'h1C, 1'b0, 1'b0);
    pop_expect(8'h1C, 1'b0, 1'b0);
    pop_expect(8'h1C, 1'b1, 1'b0);
    pop_expect(8'h1C, 1'b0, 1'b0);
`endif
    chk("t8_empty", 32'(ev_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
